// File: rtl/mac_lane_demux.sv
// Ping-pong frame buffer that fans each input beat out to LANES byte lanes.
// Ports: s_axis_input_* (wide AXIS sink), m_axis_output_* (per-lane sources),
//        frame_overflow (1-cycle pulse), frames_sent (16-bit drained count).
module mac_lane_demux #(
    parameter int LANES     = 8,
    parameter int LANE_W    = 8,
    parameter int FRAME_LEN = 236
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_axis_input_tvalid,
    output logic                          s_axis_input_tready,
    input  logic [LANES*LANE_W-1:0]       s_axis_input_tdata,
    input  logic                          s_axis_input_tlast,
    output logic [LANES-1:0]              m_axis_output_tvalid,
    input  logic [LANES-1:0]              m_axis_output_tready,
    output logic [LANES-1:0][LANE_W-1:0]  m_axis_output_tdata,
    output logic [LANES-1:0]              m_axis_output_tlast,
    output logic                          frame_overflow,
    output logic [15:0]                   frames_sent
);

    localparam int DW = LANES * LANE_W;
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] FL = CW'(FRAME_LEN);

    typedef enum logic [1:0] {
        B_FREE,
        B_FILLING,
        B_FULL
    } bank_st_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_SEND,
        L_DONE
    } lane_st_t;

    logic [DW-1:0] mem [2][FRAME_LEN];

    bank_st_t      bank_st  [2];
    logic [CW-1:0] bank_len [2];
    logic          wr_bank;
    logic          rd_bank;
    logic [CW-1:0] wr_addr;
    logic          ovf_seen;
    logic          live;
    logic          start_q;
    logic          accept;
    logic          saturated;
    logic          drain;
    logic [CW-1:0] rd_len;
    logic [LANES-1:0] done;

    // live keeps the sink closed until the first clock edge after reset.
    assign s_axis_input_tready = live && (bank_st[wr_bank] != B_FULL);
    assign accept    = s_axis_input_tvalid && s_axis_input_tready;
    assign saturated = (wr_addr == FL);
    assign drain     = &done;
    assign rd_len    = bank_len[rd_bank];

    always_ff @(posedge clk) begin
        if (accept && !saturated) begin
            mem[wr_bank][wr_addr[AW-1:0]] <= s_axis_input_tdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_st[0]     <= B_FREE;
            bank_st[1]     <= B_FREE;
            bank_len[0]    <= '0;
            bank_len[1]    <= '0;
            wr_bank        <= 1'b0;
            wr_addr        <= '0;
            ovf_seen       <= 1'b0;
            live           <= 1'b0;
            frame_overflow <= 1'b0;
        end else begin
            live           <= 1'b1;
            frame_overflow <= 1'b0;
            // Release and write never touch the same bank: a full write
            // bank blocks acceptance.
            if (drain) begin
                bank_st[rd_bank] <= B_FREE;
            end
            if (accept) begin
                if (saturated && !ovf_seen) begin
                    frame_overflow <= 1'b1;
                    ovf_seen       <= 1'b1;
                end
                if (s_axis_input_tlast) begin
                    bank_st[wr_bank]  <= B_FULL;
                    bank_len[wr_bank] <= saturated ? FL
                                                   : wr_addr + CW'(1);
                    wr_bank  <= ~wr_bank;
                    wr_addr  <= '0;
                    ovf_seen <= 1'b0;
                end else begin
                    bank_st[wr_bank] <= B_FILLING;
                    if (!saturated) begin
                        wr_addr <= wr_addr + CW'(1);
                    end
                end
            end
        end
    end

    // start_q delays the lane start by one cycle after the bank fills and
    // is forced low on release so lanes never see the stale bank state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_bank     <= 1'b0;
            start_q     <= 1'b0;
            frames_sent <= '0;
        end else begin
            start_q <= (bank_st[rd_bank] == B_FULL) && !drain;
            if (drain) begin
                rd_bank     <= ~rd_bank;
                frames_sent <= frames_sent + 16'd1;
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        lane_st_t          st;
        lane_st_t          st_nx;
        logic [CW-1:0]     addr;
        logic [CW-1:0]     addr_nx;
        logic [LANE_W-1:0] word;
        logic              last;

        assign word = mem[rd_bank][addr[AW-1:0]][j*LANE_W +: LANE_W];
        assign last = (addr == rd_len - CW'(1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st   <= L_IDLE;
                addr <= '0;
            end else begin
                st   <= st_nx;
                addr <= addr_nx;
            end
        end

        always_comb begin
            st_nx   = st;
            addr_nx = addr;
            if (drain) begin
                st_nx   = L_IDLE;
                addr_nx = '0;
            end else begin
                unique case (st)
                    L_IDLE: begin
                        if (start_q) begin
                            st_nx = L_SEND;
                        end
                    end
                    L_SEND: begin
                        if (m_axis_output_tready[j]) begin
                            if (last) begin
                                st_nx = L_DONE;
                            end else begin
                                addr_nx = addr + CW'(1);
                            end
                        end
                    end
                    L_DONE: begin
                        st_nx = L_DONE;
                    end
                    default: begin
                        st_nx = L_IDLE;
                    end
                endcase
            end
        end

        assign done[j] = (st == L_DONE);
        assign m_axis_output_tvalid[j] = (st == L_SEND);
        assign m_axis_output_tlast[j]  = (st == L_SEND) && last;
        assign m_axis_output_tdata[j]  = (st == L_SEND) ? word : '0;
    end

endmodule

// File: tb/tb_mac_lane_demux.sv
// Directed bench for mac_lane_demux with default parameters.
// Ports: none (drives clock, reset, AXIS source and eight lane sinks).
module tb_mac_lane_demux;

    logic             clk;
    logic             reset;
    logic             ivalid;
    logic             iready;
    logic [63:0]      idata;
    logic             ilast;
    logic [7:0]       ovalid;
    logic [7:0]       m_rdy;
    logic [7:0][7:0]  odata;
    logic [7:0]       olast;
    logic             ovf;
    logic [15:0]      fsent;

    mac_lane_demux dut (
        .clk                  (clk),
        .reset                (reset),
        .s_axis_input_tvalid  (ivalid),
        .s_axis_input_tready  (iready),
        .s_axis_input_tdata   (idata),
        .s_axis_input_tlast   (ilast),
        .m_axis_output_tvalid (ovalid),
        .m_axis_output_tready (m_rdy),
        .m_axis_output_tdata  (odata),
        .m_axis_output_tlast  (olast),
        .frame_overflow       (ovf),
        .frames_sent          (fsent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    int rdy_mode = 1;
    int cyc = 0;
    int stall_err = 0;
    int ovf_cnt = 0;
    int ovf_beat = -1;
    int fs_first = -1;

    logic [7:0] rx_d [8][$];
    logic       rx_l [8][$];
    int         rx_c [8][$];
    logic [7:0] prev_stall;
    logic [7:0][7:0] prev_d;
    logic [7:0] prev_l;

    function automatic logic [7:0] pat(input int f, input int b,
                                       input int j);
        return 8'((b + j + 32 * f) & 255);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane sinks: ready pattern, handshake capture, hold-stability check.
    always @(negedge clk) begin
        cyc++;
        case (rdy_mode)
            0: m_rdy = 8'h00;
            2: begin
                m_rdy = 8'hFF;
                m_rdy[3] = 1'($urandom_range(0, 1));
            end
            default: m_rdy = 8'hFF;
        endcase
        if (reset) begin
            prev_stall = '0;
        end else begin
            for (int j = 0; j < 8; j++) begin
                if (prev_stall[j]) begin
                    if (!(ovalid[j] && odata[j] == prev_d[j] &&
                          olast[j] == prev_l[j]))
                        stall_err++;
                end
                if (ovalid[j] && m_rdy[j]) begin
                    rx_d[j].push_back(odata[j]);
                    rx_l[j].push_back(olast[j]);
                    rx_c[j].push_back(cyc);
                end
                prev_stall[j] = ovalid[j] && !m_rdy[j];
                prev_d[j] = odata[j];
                prev_l[j] = olast[j];
            end
        end
    end

    task automatic clear_rx();
        for (int j = 0; j < 8; j++) begin
            rx_d[j].delete();
            rx_l[j].delete();
            rx_c[j].delete();
        end
    endtask

    task automatic send_frame(input int n, input int f);
        int guard;
        int tmo;
        tmo = 0;
        for (int b = 0; b < n; b++) begin
            ivalid = 1'b1;
            ilast  = (b == n - 1);
            for (int j = 0; j < 8; j++) idata[j*8 +: 8] = pat(f, b, j);
            guard = 0;
            while (!iready && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 3000) tmo = 1;
            @(negedge clk);
            if (ovf) begin
                ovf_cnt++;
                ovf_beat = b;
            end
            if (b == 0) fs_first = int'(fsent);
            if (tmo != 0) break;
        end
        ivalid = 1'b0;
        ilast  = 1'b0;
        chk("send_timeout", 64'(tmo), 64'd0);
    endtask

    task automatic wait_fs(input string tag, input int tgt);
        for (int i = 0; i < 3000 && int'(fsent) != tgt; i++)
            @(negedge clk);
        chk(tag, 64'(fsent), 64'(tgt));
    endtask

    task automatic check_lanes(input string tag, input int nfr,
                               input int f0, input int len);
        int bad_n;
        int bad_d;
        int f;
        int b;
        bad_n = 0;
        bad_d = 0;
        for (int j = 0; j < 8; j++) begin
            if (rx_d[j].size() != nfr * len) begin
                bad_n++;
            end else begin
                for (int k = 0; k < nfr * len; k++) begin
                    f = f0 + k / len;
                    b = k % len;
                    if (rx_d[j][k] !== pat(f, b, j) ||
                        rx_l[j][k] !== (b == len - 1))
                        bad_d++;
                end
            end
        end
        chk({tag, "_cnt"}, 64'(bad_n), 64'd0);
        chk({tag, "_dat"}, 64'(bad_d), 64'd0);
    endtask

    initial begin
        int bad;
        reset  = 1'b1;
        ivalid = 1'b0;
        ilast  = 1'b0;
        idata  = '0;
        m_rdy  = 8'hFF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tready", 64'(iready), 64'd0);
        chk("rst_tvalid", 64'(ovalid), 64'd0);
        chk("rst_tlast", 64'(olast), 64'd0);
        chk("rst_tdata", odata, 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_fsent", 64'(fsent), 64'd0);
        reset = 1'b0;
        #1;
        chk("rdy_pre_edge", 64'(iready), 64'd0);
        @(negedge clk);
        chk("rdy_post_edge", 64'(iready), 64'd1);

        // Single-beat frame
        clear_rx();
        ivalid = 1'b1;
        ilast  = 1'b1;
        idata  = 64'h0102030405060708;
        @(negedge clk);
        ivalid = 1'b0;
        ilast  = 1'b0;
        chk("sb_v_e0", 64'(ovalid), 64'd0);
        @(negedge clk);
        chk("sb_v_e1", 64'(ovalid), 64'd0);
        @(negedge clk);
        chk("sb_v_e2", 64'(ovalid), 64'hFF);
        chk("sb_last", 64'(olast), 64'hFF);
        chk("sb_lane0", 64'(odata[0]), 64'h08);
        chk("sb_lane7", 64'(odata[7]), 64'h01);
        wait_fs("sb_fs", 1);

        // Full 236-beat frame
        clear_rx();
        send_frame(236, 0);
        wait_fs("full_fs", 2);
        check_lanes("full", 1, 0, 236);

        // 240-beat frame overflows at the 237th beat
        clear_rx();
        ovf_cnt = 0;
        send_frame(240, 1);
        chk("ovf_cnt", 64'(ovf_cnt), 64'd1);
        chk("ovf_beat", 64'(ovf_beat), 64'd236);
        wait_fs("ovf_fs", 3);
        check_lanes("ovf", 1, 1, 236);

        // Three frames with all lanes stalled
        clear_rx();
        rdy_mode = 0;
        send_frame(10, 2);
        send_frame(10, 3);
        chk("both_full_rdy", 64'(iready), 64'd0);
        repeat (5) @(negedge clk);
        chk("both_full_hold", 64'(iready), 64'd0);
        rdy_mode = 1;
        send_frame(10, 4);
        chk("f3_after_rel", 64'(fs_first), 64'd4);
        wait_fs("bp_fs", 6);
        check_lanes("bp", 3, 2, 10);

        // Lane 3 randomly stalled, frames must not overlap
        clear_rx();
        rdy_mode = 2;
        send_frame(12, 5);
        send_frame(12, 6);
        wait_fs("l3_fs", 8);
        rdy_mode = 1;
        check_lanes("l3", 2, 5, 12);
        bad = 0;
        if (rx_c[3].size() < 12) begin
            bad = 8;
        end else begin
            for (int j = 0; j < 8; j++)
                if (rx_c[j].size() < 13 || rx_c[j][12] <= rx_c[3][11])
                    bad++;
        end
        chk("l3_gate", 64'(bad), 64'd0);

        // Reset in the middle of lane output
        rdy_mode = 0;
        send_frame(5, 6);
        for (int i = 0; i < 50 && !ovalid[0]; i++) @(negedge clk);
        chk("mid_l0_busy", 64'(ovalid[0]), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tvalid", 64'(ovalid), 64'd0);
        chk("mid_rst_tdata", odata, 64'd0);
        chk("mid_rst_tlast", 64'(olast), 64'd0);
        chk("mid_rst_tready", 64'(iready), 64'd0);
        chk("mid_rst_fsent", 64'(fsent), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_rx();
        rdy_mode = 1;
        send_frame(5, 7);
        wait_fs("post_rst_fs", 1);
        check_lanes("post_rst", 1, 7, 5);

        chk("stall_stable", 64'(stall_err), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
